// File: rtl/axi_lite_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_slave_if
// Description : AXI-Lite channel bundle between the muxed IFU/LSU master and
//               the SRAM slave model. Read address/data, write address/data
//               and write response channels.
//               master modport : drives AR/AW/W valids and payload, R/B ready
//               slave  modport : drives ready for AR/AW/W, R/B valid+payload
// Revision    : 1.0  initial release
// ============================================================================
interface axi_lite_sram_slave_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_slave
// Description : AXI-Lite slave memory model with fixed read/write response
//               latencies. One transaction in flight at a time. Word-addressed
//               backing store with byte-strobe writes; out-of-range accesses
//               answer SLVERR.
// Ports       : clk   - system clock (rising edge)
//               rst_n - asynchronous active-low reset
//               bus   - AXI-Lite slave modport (AR, R, AW, W, B channels)
// Revision    : 1.0  initial release
// ============================================================================
module axi_lite_sram_slave #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned WR_LAT     = 1
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   axi_lite_sram_slave_if.slave bus
);

   localparam int unsigned C_DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [31:0] C_SPAN   = 32'd4 << DEPTH_LOG2;
   localparam logic [3:0]  C_RD_CNT = 4'(RD_LAT - 1);
   localparam logic [3:0]  C_WR_CNT = 4'(WR_LAT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_R_WAIT = 3'd1;
   localparam logic [2:0] S_R_RESP = 3'd2;
   localparam logic [2:0] S_W_WAIT = 3'd3;
   localparam logic [2:0] S_B_RESP = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  in_range_q, in_range_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [1:0]            bresp_q, bresp_d;

   logic [31:0]           mem_q [0:C_DEPTH-1];

   // Address decode; the subtraction wraps so addresses below BASE_ADDR land
   // far above the span and fail the range compare.
   logic [31:0]           w_ar_off, w_aw_off;
   logic                  w_ar_in, w_aw_in;
   logic [DEPTH_LOG2-1:0] w_ar_idx, w_aw_idx;

   assign w_ar_off = bus.araddr - BASE_ADDR;
   assign w_aw_off = bus.awaddr - BASE_ADDR;
   assign w_ar_in  = (w_ar_off < C_SPAN);
   assign w_aw_in  = (w_aw_off < C_SPAN);
   assign w_ar_idx = w_ar_off[DEPTH_LOG2+1:2];
   assign w_aw_idx = w_aw_off[DEPTH_LOG2+1:2];

   logic w_idle, w_ar_hs, w_aw_hs;
   assign w_idle  = (state_q == S_IDLE);
   assign w_ar_hs = w_idle & bus.arvalid;
   assign w_aw_hs = w_idle & bus.awvalid & bus.wvalid & ~bus.arvalid;

   // With a latency of 1 the response state is entered on the handshake edge
   // itself, so the command view must come from the live bus in IDLE.
   logic [DEPTH_LOG2-1:0] w_cmd_idx;
   logic                  w_cmd_in;
   logic [31:0]           w_cmd_wdata;
   logic [3:0]            w_cmd_wstrb;

   assign w_cmd_idx   = w_idle ? (bus.arvalid ? w_ar_idx : w_aw_idx) : idx_q;
   assign w_cmd_in    = w_idle ? (bus.arvalid ? w_ar_in  : w_aw_in)  : in_range_q;
   assign w_cmd_wdata = w_idle ? bus.wdata : wdata_q;
   assign w_cmd_wstrb = w_idle ? bus.wstrb : wstrb_q;

   logic w_enter_r, w_enter_b;
   assign w_enter_r = (state_d == S_R_RESP) && (state_q != S_R_RESP);
   assign w_enter_b = (state_d == S_B_RESP) && (state_q != S_B_RESP);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         wdata_q    <= 32'd0;
         wstrb_q    <= 4'd0;
         rdata_q    <= 32'd0;
         rresp_q    <= 2'b00;
         bresp_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         bresp_q    <= bresp_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_ar_hs) begin
               state_d = (RD_LAT == 1) ? S_R_RESP : S_R_WAIT;
               cnt_d   = C_RD_CNT;
            end else if (w_aw_hs) begin
               state_d = (WR_LAT == 1) ? S_B_RESP : S_W_WAIT;
               cnt_d   = C_WR_CNT;
            end
         end
         S_R_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_R_RESP;
         end
         S_R_RESP: begin
            if (bus.rready) state_d = S_IDLE;
         end
         S_W_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_B_RESP;
         end
         S_B_RESP: begin
            if (bus.bready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      idx_d      = idx_q;
      in_range_d = in_range_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      bresp_d    = bresp_q;
      if (w_ar_hs) begin
         idx_d      = w_ar_idx;
         in_range_d = w_ar_in;
      end else if (w_aw_hs) begin
         idx_d      = w_aw_idx;
         in_range_d = w_aw_in;
         wdata_d    = bus.wdata;
         wstrb_d    = bus.wstrb;
      end
      if (w_enter_r) begin
         rdata_d = w_cmd_in ? mem_q[w_cmd_idx] : 32'd0;
         rresp_d = w_cmd_in ? 2'b00 : 2'b10;
      end
      if (w_enter_b) begin
         bresp_d = w_cmd_in ? 2'b00 : 2'b10;
      end
   end

   // Backing store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_enter_b && w_cmd_in) begin
         for (int b = 0; b < 4; b++) begin
            if (w_cmd_wstrb[b]) mem_q[w_cmd_idx][8*b +: 8] <= w_cmd_wdata[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      bus.arready = w_idle;
      bus.awready = w_aw_hs;
      bus.wready  = w_aw_hs;
      bus.rvalid  = (state_q == S_R_RESP);
      bus.bvalid  = (state_q == S_B_RESP);
      bus.rdata   = rdata_q;
      bus.rresp   = rresp_q;
      bus.bresp   = bresp_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_sram_slave
// Description : Self-checking bench for axi_lite_sram_slave. Directed
//               scenarios plus randomized traffic against an array-based
//               reference memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_sram_slave;

   localparam logic [31:0] C_BASE   = 32'h8000_0000;
   localparam int          C_RD_LAT = 2;
   localparam int          C_WR_LAT = 1;
   localparam int          C_BOUND  = 50;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   axi_lite_sram_slave_if bus ();

   axi_lite_sram_slave #(
      .DEPTH_LOG2 (10),
      .BASE_ADDR  (C_BASE),
      .RD_LAT     (C_RD_LAT),
      .WR_LAT     (C_WR_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   logic [31:0] mdl [int];

   function automatic bit m_in(input logic [31:0] a);
      return (a >= C_BASE) && (a < C_BASE + 32'd4096);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - C_BASE) / 4);
   endfunction

   function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] old, mask;
      if (!m_in(a)) return 2'b10;
      old  = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'd0;
      mask = 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
      mdl[m_idx(a)] = (old & ~mask) | (d & mask);
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] a);
      if (!m_in(a)) return 32'd0;
      return mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'd0;
   endfunction

   function automatic logic [1:0] m_rresp(input logic [31:0] a);
      return m_in(a) ? 2'b00 : 2'b10;
   endfunction

   // ----------------------------------------------------------- bus drivers
   task automatic idle_bus();
      bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
      bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0;
      bus.wvalid = 0; bus.bready = 0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output bit tmo, output int lat, output logic [1:0] resp);
      int n;
      tmo = 0; lat = 0; resp = 2'bxx;
      @(negedge clk);
      bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
      bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
      n = 0;
      while (!bus.awready && n < C_BOUND) begin @(negedge clk); n++; end
      if (n == C_BOUND) begin tmo = 1; idle_bus(); return; end
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0;
      do begin @(negedge clk); lat++; end while (!bus.bvalid && lat < C_BOUND);
      if (!bus.bvalid) begin tmo = 1; idle_bus(); return; end
      resp = bus.bresp;
      @(posedge clk); #1;
      bus.bready = 0;
   endtask

   task automatic do_read(input logic [31:0] a, output bit tmo, output int lat,
                          output logic [31:0] d, output logic [1:0] resp);
      int n;
      tmo = 0; lat = 0; d = 'x; resp = 2'bxx;
      @(negedge clk);
      bus.araddr = a; bus.arvalid = 1; bus.rready = 0;
      n = 0;
      while (!bus.arready && n < C_BOUND) begin @(negedge clk); n++; end
      if (n == C_BOUND) begin tmo = 1; idle_bus(); return; end
      @(posedge clk); #1;
      bus.arvalid = 0;
      do begin @(negedge clk); lat++; end while (!bus.rvalid && lat < C_BOUND);
      if (!bus.rvalid) begin tmo = 1; idle_bus(); return; end
      d = bus.rdata; resp = bus.rresp;
      bus.rready = 1;
      @(posedge clk); #1;
      bus.rready = 0;
   endtask

   // --------------------------------------------------------------- scenarios
   task automatic test_reset();
      idle_bus();
      rst_n = 1;
      #2 rst_n = 0;
      #1;
      n_checks++;
      if ({bus.arready, bus.rvalid, bus.bvalid} !== 3'b100)
         $display("FAIL reset_ctrl: arready/rvalid/bvalid=%b want 100",
                  {bus.arready, bus.rvalid, bus.bvalid});
      else n_pass++;
      n_checks++;
      if ({bus.rdata, bus.rresp, bus.bresp} !== 36'd0)
         $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b want 0/00/00",
                  bus.rdata, bus.rresp, bus.bresp);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_write_read();
      bit tmo; int lat; logic [1:0] resp; logic [31:0] d;
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, tmo, lat, resp);
      void'(m_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF));
      n_checks++;
      if (tmo || lat != 1 || resp !== 2'b00)
         $display("FAIL wr_basic: tmo=%0d lat=%0d bresp=%b want 0/1/00", tmo, lat, resp);
      else n_pass++;
      do_read(32'h8000_0010, tmo, lat, d, resp);
      n_checks++;
      if (tmo || lat != 2)
         $display("FAIL rd_latency: tmo=%0d lat=%0d want 0/2", tmo, lat);
      else n_pass++;
      n_checks++;
      if (d !== 32'hDEAD_BEEF || resp !== 2'b00)
         $display("FAIL rd_basic: rdata=%h rresp=%b want deadbeef/00", d, resp);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      bit tmo; int lat; logic [1:0] resp; logic [31:0] d; bit bad;
      @(negedge clk);
      bus.araddr = 32'h8000_0010; bus.arvalid = 1;
      @(posedge clk); #1;
      bus.arvalid = 0;
      #2 rst_n = 0;   // mid-cycle, no clock edge involved
      #1;
      n_checks++;
      if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1)
         $display("FAIL rst_mid_read: rvalid=%b arready=%b want 0/1", bus.rvalid, bus.arready);
      else n_pass++;
      @(negedge clk) rst_n = 1;
      bad = 0;
      repeat (4) @(negedge clk) if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) bad = 1;
      n_checks++;
      if (bad) $display("FAIL rst_dropped: dropped read resurfaced, got=1 want=0");
      else n_pass++;
      do_read(32'h8000_0010, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== 32'hDEAD_BEEF || resp !== 2'b00)
         $display("FAIL rst_retain: tmo=%0d rdata=%h want deadbeef", tmo, d);
      else n_pass++;
   endtask

   task automatic test_strobes();
      bit tmo; int lat; logic [1:0] resp; logic [31:0] d;
      do_write(32'h8000_0010, 32'h1122_3344, 4'hF, tmo, lat, resp);
      void'(m_write(32'h8000_0010, 32'h1122_3344, 4'hF));
      do_write(32'h8000_0010, 32'hAABB_CCDD, 4'b0101, tmo, lat, resp);
      void'(m_write(32'h8000_0010, 32'hAABB_CCDD, 4'b0101));
      n_checks++;
      if (tmo || resp !== 2'b00)
         $display("FAIL strb_wr: tmo=%0d bresp=%b want 0/00", tmo, resp);
      else n_pass++;
      do_read(32'h8000_0013, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== 32'h11BB_33DD || resp !== 2'b00)
         $display("FAIL strb_rd13: tmo=%0d rdata=%h want 11bb33dd", tmo, d);
      else n_pass++;
      do_write(32'h8000_0010, 32'h5555_5555, 4'h0, tmo, lat, resp);
      do_read(32'h8000_0010, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== m_rdata(32'h8000_0010))
         $display("FAIL strb_zero: tmo=%0d rdata=%h want %h", tmo, d, m_rdata(32'h8000_0010));
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit tmo; int lat; int n; logic [1:0] resp; logic [31:0] v; bit bad;
      v = $urandom;
      do_write(32'h8000_0020, v, 4'hF, tmo, lat, resp);
      void'(m_write(32'h8000_0020, v, 4'hF));
      @(negedge clk);
      bus.araddr = 32'h8000_0020; bus.arvalid = 1; bus.rready = 0;
      @(posedge clk); #1;
      bus.arvalid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rvalid && n < C_BOUND);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.rvalid !== 1'b1 || bus.rdata !== m_rdata(32'h8000_0020) ||
             bus.rresp !== 2'b00 || bus.arready !== 1'b0) bad = 1;
         @(negedge clk);
      end
      n_checks++;
      if (bad) $display("FAIL bp_stable: rvalid=%b rdata=%h arready=%b want 1/%h/0",
                        bus.rvalid, bus.rdata, bus.arready, m_rdata(32'h8000_0020));
      else n_pass++;
      bus.rready = 1;
      @(posedge clk); #1;
      bus.rready = 0;
      @(negedge clk);
      n_checks++;
      if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0)
         $display("FAIL bp_release: arready=%b rvalid=%b want 1/0", bus.arready, bus.rvalid);
      else n_pass++;
   endtask

   task automatic test_arbitration();
      bit tmo; int lat; int n; logic [1:0] resp; logic [31:0] d, v; bit bad;
      v = $urandom;
      @(negedge clk);
      bus.araddr = 32'h8000_0020; bus.arvalid = 1; bus.rready = 0;
      bus.awaddr = 32'h8000_0024; bus.wdata = v; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
      #1;
      n_checks++;
      if ({bus.arready, bus.awready, bus.wready} !== 3'b100)
         $display("FAIL arb_pick: ar/aw/w ready=%b want 100",
                  {bus.arready, bus.awready, bus.wready});
      else n_pass++;
      @(posedge clk); #1;
      bus.arvalid = 0;
      bad = 0; n = 0;
      do begin
         @(negedge clk); n++;
         if (bus.awready !== 1'b0 || bus.wready !== 1'b0) bad = 1;
      end while (!bus.rvalid && n < C_BOUND);
      n_checks++;
      if (bad || !bus.rvalid || bus.rdata !== m_rdata(32'h8000_0020))
         $display("FAIL arb_read: wr_accepted_early=%0d rvalid=%b rdata=%h want 0/1/%h",
                  bad, bus.rvalid, bus.rdata, m_rdata(32'h8000_0020));
      else n_pass++;
      bus.rready = 1;
      @(posedge clk); #1;
      bus.rready = 0;
      @(negedge clk);
      n_checks++;
      if (bus.awready !== 1'b1 || bus.wready !== 1'b1)
         $display("FAIL arb_write_next: awready=%b wready=%b want 1/1", bus.awready, bus.wready);
      else n_pass++;
      void'(m_write(32'h8000_0024, v, 4'hF));
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
      n = 0;
      while (!bus.bvalid && n < C_BOUND) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.bready = 0;
      do_read(32'h8000_0024, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== v)
         $display("FAIL arb_wdata: tmo=%0d rdata=%h want %h", tmo, d, v);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      bit tmo; int lat; logic [1:0] resp; logic [31:0] d, v;
      do_read(32'h8000_1000, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== 32'd0 || resp !== 2'b10)
         $display("FAIL oor_read: tmo=%0d rdata=%h rresp=%b want 0/10", tmo, d, resp);
      else n_pass++;
      v = $urandom;
      do_write(32'h8000_0FFC, v, 4'hF, tmo, lat, resp);
      void'(m_write(32'h8000_0FFC, v, 4'hF));
      do_write(32'h7FFF_FFFC, ~v, 4'hF, tmo, lat, resp);
      n_checks++;
      if (tmo || resp !== m_write(32'h7FFF_FFFC, ~v, 4'hF))
         $display("FAIL oor_write: tmo=%0d bresp=%b want 10", tmo, resp);
      else n_pass++;
      do_read(32'h8000_0FFC, tmo, lat, d, resp);
      n_checks++;
      if (tmo || d !== v || resp !== 2'b00)
         $display("FAIL oor_word1023: tmo=%0d rdata=%h rresp=%b want %h/00", tmo, d, resp, v);
      else n_pass++;
   endtask

   task automatic test_random();
      bit tmo; int lat; logic [1:0] resp, eresp; logic [31:0] d, a, v; logic [3:0] s;
      for (int i = 0; i < 16; i++) begin
         a = C_BASE + 32'h100 + 32'(4 * i);
         v = $urandom;
         do_write(a, v, 4'hF, tmo, lat, resp);
         void'(m_write(a, v, 4'hF));
      end
      for (int i = 0; i < 40; i++) begin
         case ($urandom % 8)
            0:       a = 32'h8000_1000 + 32'(4 * ($urandom % 16));
            1:       a = 32'h7FFF_FF00 + 32'($urandom % 256);
            default: a = C_BASE + 32'h100 + 32'(4 * ($urandom % 16)) + 32'($urandom % 4);
         endcase
         if ($urandom % 2 == 1) begin
            v = $urandom; s = 4'($urandom);
            do_write(a, v, s, tmo, lat, resp);
            eresp = m_write(a, v, s);
            n_checks++;
            if (tmo || lat != C_WR_LAT || resp !== eresp)
               $display("FAIL rnd_wr[%0d]: addr=%h tmo=%0d lat=%0d bresp=%b want lat %0d bresp %b",
                        i, a, tmo, lat, resp, C_WR_LAT, eresp);
            else n_pass++;
         end else begin
            do_read(a, tmo, lat, d, resp);
            n_checks++;
            if (tmo || lat != C_RD_LAT || d !== m_rdata(a) || resp !== m_rresp(a))
               $display("FAIL rnd_rd[%0d]: addr=%h tmo=%0d lat=%0d rdata=%h rresp=%b want %0d/%h/%b",
                        i, a, tmo, lat, d, resp, C_RD_LAT, m_rdata(a), m_rresp(a));
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_reset_mid_read();
      test_strobes();
      test_backpressure();
      test_arbitration();
      test_out_of_range();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
